// File: rtl/leibniz_pkg.sv
// Shared types and constants for the Leibniz pi term generator and its accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default widths, NUMERATOR = 4 << Q, FSM state enum, term record.
package leibniz_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int Q_DEF     = 15;
  localparam int IDXW_DEF  = 16;

  // 4.0 in Q-format fixed point; dividing it by 2k+1 gives the term magnitude.
  localparam logic [WIDTH_DEF-1:0] NUMERATOR = WIDTH_DEF'(4) << Q_DEF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DIV  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // One emitted term, as consumed by the downstream accumulator.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic                 sign;
    logic [IDXW_DEF-1:0]  index;
    logic                 last;
  } term_t;

endpackage

// File: rtl/leibniz_term_gen_div.sv
// Sequential restoring divider, one quotient bit per cycle.
// Latency: load cycle, then WIDTH iteration cycles; results valid the cycle after done.
// Backpressure: none; load is only honoured by the caller when the divider is idle.
// Ports: clk, reset (sync, active-high), load, dividend, divisor -> busy, done
//        (high during the final iteration), quotient, remainder.
module seq_restoring_div #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, quot_q;
  logic [CNTW-1:0]  cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   rem_sh, rem_sub, rem_d;
  logic             ge;
  logic             unused_rem_msb;

  // Compare/subtract one bit wider than the operands so the shifted
  // remainder can never overflow before the compare.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};
    rem_d   = ge ? rem_sub : rem_sh;
  end

  // Post-step remainder is always below the divisor, so its MSB is zero.
  assign unused_rem_msb = rem_d[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      rem_q  <= '0;
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      quot_q <= '0;
      cnt_q  <= CNTW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], ge};
      dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNTW'(1);
      end
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/leibniz_term_gen.sv
// Leibniz pi term source: emits floor(NUMERATOR/(2k+1)) with alternating sign for k = 0..n_terms-1.
// Latency: WIDTH+2 cycles per term (LOAD, WIDTH divide steps, OUT) with term_ready held high.
// Backpressure: valid/ready; term fields hold while term_valid && !term_ready.
// Ports: clk, reset (sync, active-high), start, n_terms -> term_data/sign/index/last/valid,
//        term_ready in; busy (run in progress), done (held until next start).
module leibniz_term_gen
  import leibniz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q     = Q_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDXW-1:0]  n_terms,
  output logic [WIDTH-1:0] term_data,
  output logic             term_sign,
  output logic [IDXW-1:0]  term_index,
  output logic             term_last,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] NUM = WIDTH'(4) << Q;

  state_t          state_q;
  logic [IDXW-1:0] k_q, nterms_q;
  logic            valid_q, last_q, busy_q, done_q;

  logic [WIDTH-1:0] den_d, div_quot, div_rem;
  logic             div_load, div_busy, div_done;
  logic             unused_div;

  // 2k+1 built by concatenation at IDXW+1 bits, so it never wraps.
  assign den_d    = {{(WIDTH-IDXW-1){1'b0}}, k_q, 1'b1};
  assign div_load = (state_q == S_LOAD);

  // Remainder is not needed for the term; busy is implied by the FSM state.
  assign unused_div = ^{div_rem, div_busy};

  seq_restoring_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (NUM),
    .divisor   (den_d),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      nterms_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (n_terms == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              nterms_q <= n_terms;
              k_q      <= '0;
              done_q   <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          state_q <= S_DIV;
        end
        S_DIV: begin
          // div_done marks the final step; the quotient register is
          // complete on the same edge that raises term_valid.
          if (div_done) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            last_q  <= (k_q == nterms_q - IDXW'(1));
          end
        end
        S_OUT: begin
          if (term_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              k_q     <= k_q + IDXW'(1);
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The divider sits idle in OUT, so its quotient register holds the term.
  assign term_data  = div_quot;
  assign term_sign  = k_q[0];
  assign term_index = k_q;
  assign term_last  = last_q;
  assign term_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/leibniz_term_gen.md
Name: leibniz_term_gen

Overview:
- Upstream source stage for the Leibniz pi accumulator. For k = 0 .. n_terms-1, it generates the odd denominator 2k+1.
- Each term is computed as floor(NUMERATOR / (2k+1)) with an iterative restoring divider. This replaces the array of parallel divider IP instances.
- Each term is emitted with its alternating sign over a valid/ready stream. The downstream accumulator adds or subtracts it.

Parameters:
- WIDTH, 64, datapath width of numerator, denominator, remainder and quotient.
- Q, 15, fixed-point fraction bits. NUMERATOR = 4 << Q (131072 at default).
- IDXW, 16, width of term count and index.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse that begins a run. Sampled only in IDLE or DONE.
- n_terms  input  IDXW  number of terms to produce. Latched on start.
- term_data  output  WIDTH  unsigned magnitude floor(NUMERATOR/(2k+1)).
- term_sign  output  1  0 = add (k even), 1 = subtract (k odd).
- term_index  output  IDXW  k of the presented term.
- term_last  output  1  high with the term where k = n_terms-1.
- term_valid  output  1  term fields are valid.
- term_ready  input  1  downstream accepts the term.
- busy  output  1  high from the cycle after start until DONE is entered.
- done  output  1  held high in DONE until the next start or reset.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - state = IDLE.
  - All outputs = 0.
  - k = 0; the divider registers are cleared.
- States: IDLE, LOAD, DIV, OUT, DONE.
- IDLE/DONE + start:
  - If n_terms = 0, go to DONE directly. done stays/reasserts high and no term is emitted.
  - Otherwise latch n_terms, set k = 0, clear done, go to LOAD.
- LOAD (1 cycle):
  - Remainder = 0, dividend shift register = NUMERATOR, divisor = 2k+1 (zero-extended to WIDTH), bit counter = WIDTH-1.
  - Go to DIV.
- DIV (exactly WIDTH cycles, one quotient bit per cycle):
  - Shift remainder left by 1, bringing in the dividend MSB.
  - If remainder >= divisor, subtract the divisor and set the quotient LSB to 1; else set it to 0.
  - Compare and subtract at WIDTH+1 bits so there is no overflow.
  - After the cycle with bit counter = 0, go to OUT.
- OUT:
  - term_valid = 1. term_data, term_sign = k[0], term_index = k and term_last are registered.
  - These fields are held stable while term_valid && !term_ready.
  - Transfer happens on a cycle with term_valid && term_ready. On that cycle:
    - if term_last, go to DONE;
    - else k <= k+1 and go to LOAD.
  - term_valid drops the cycle after the transfer.
- Latency: WIDTH+2 cycles per term from LOAD entry to first valid under ready = 1. At default that is 66 cycles per term.
- Divide by zero cannot occur, because the denominator is always odd and at least 1.
- Denominator overflow: 2k+1 is computed at IDXW+1 bits, so it never wraps.
- start while busy (LOAD/DIV/OUT) is ignored.
- Reset mid-DIV or mid-OUT aborts immediately. No partial term is emitted and term_valid = 0 on the next cycle.
- term_ready high while term_valid = 0 has no effect.
- Simultaneous transfer of the last term and a start pulse: the transfer completes and the block goes to DONE. The start is ignored because it was sampled outside IDLE/DONE.

Decomposition:
- Shared package leibniz_pkg holds:
  - the state enum typedef;
  - the WIDTH, Q and IDXW defaults;
  - the NUMERATOR constant (4 << Q);
  - a term struct {data, sign, index, last}, reused by the downstream accumulator.
- One natural sub-module, seq_restoring_div.
  - Handshake: load/busy/done.
  - Parameter: WIDTH.
  - Inputs: dividend, divisor. Outputs: quotient, remainder.
  - The top FSM sequences denominators and owns the output handshake.

Test Plan:
- n_terms = 4, term_ready always 1 -> four terms in order:
  - (131072, +, 0), (43690, −, 1), (26214, +, 2), (18724, −, 3);
  - term_last only on index 3;
  - done rises after the fourth transfer;
  - signed sum = 94872.
- Backpressure: n_terms = 2, term_ready held 0 for 10 cycles once valid -> term_data = 131072 stays stable and term_valid stays high. The second term starts only after ready = 1 for one cycle.
- n_terms = 0 with start -> no term_valid ever, done = 1 the cycle after start, busy never high.
- Reset asserted at DIV cycle 20 of term k = 1 -> next cycle: state IDLE, all outputs 0. A new start with n_terms = 1 yields exactly (131072, +, 0, last = 1).
- start pulsed again during DIV of a 3-term run -> ignored: exactly 3 terms and a single done assertion.
- n_terms = 1000, ready = 1 -> term index 999 has denominator 1999 and data = 65 (131072/1999 = 65.57). Term spacing is 66 cycles at the default WIDTH.
